adder_traffic_sched: RTL and testbench



---
 rtl/adder_traffic_sched.sv | 232 +++++++++++++++++++++++
 tb/tb_adder_traffic_sched.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_traffic_sched.sv
// adder_traffic_sched: packetized operand generator for the shared N-bit adder.
// Sends cfg_pkts packets of cfg_payload flits with cfg_gap idle cycles after each
// packet, and folds the adder sum into a rotate-XOR signature.
// Optional build macro ADDER_SCHED_LFSR_EN: operands come from a 2N-bit Fibonacci
// LFSR (seeded all-ones at start, never reset per packet) instead of the
// thermometer fill/drain pattern.
// All outputs are registered and trail the FSM state by one cycle, so the first
// flit is visible one cycle after start is sampled and done one cycle after the
// last flit or gap cycle.
module adder_traffic_sched #(
  parameter int N   = 15,
  parameter int SEG = 4,
  parameter int CW  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [CW-1:0] cfg_pkts,
  input  logic [CW-1:0] cfg_payload,
  input  logic [CW-1:0] cfg_gap,
  input  logic [N-1:0]  sum_in,
  output logic [N-1:0]  op_a,
  output logic [N-1:0]  op_b,
  output logic          op_valid,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  sig
);

  localparam int W    = 2 * N;
  localparam int KMAX = ((W - 1) / SEG) * SEG;

  localparam logic [W-1:0] ONES        = '1;
  // SEG ones at the MSB end: first fill step
  localparam logic [W-1:0] FILL_FIRST  = ~(ONES >> SEG);
  // KMAX ones at the LSB end: first drain step
  localparam logic [W-1:0] DRAIN_FIRST = ONES >> (W - KMAX);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  // Thermometer step. Fill patterns always own the MSB and never bit 0 (KMAX < W);
  // drain patterns own bit 0 and never the MSB, so the MSB alone tells the phase.
  function automatic logic [W-1:0] therm_next(input logic [W-1:0] p);
    if (p == '0)          return FILL_FIRST;
    else if (p[W-1]) begin
      if (p[W-KMAX])      return DRAIN_FIRST;    // fill is full, flip to drain
      else                return p | (p >> SEG);
    end
    else                  return p >> SEG;       // drain; last step yields 0
  endfunction

`ifdef ADDER_SCHED_LFSR_EN
  // Maximal-length tap sets (1-based tap positions) for common widths.
  function automatic logic [W-1:0] tap_mask(input int w);
    logic [W-1:0] m;
    m = '0;
    case (w)
      16:      begin m[15] = 1'b1; m[14] = 1'b1; m[12] = 1'b1; m[3]  = 1'b1; end
      24:      begin m[23] = 1'b1; m[22] = 1'b1; m[21] = 1'b1; m[16] = 1'b1; end
      32:      begin m[31] = 1'b1; m[21] = 1'b1; m[1]  = 1'b1; m[0]  = 1'b1; end
      default: begin m[W-1] = 1'b1; m[5] = 1'b1; m[3] = 1'b1; m[0] = 1'b1; end
    endcase
    return m;
  endfunction

  localparam logic [W-1:0] TAPS = tap_mask(W);

  function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] s);
    return {s[W-2:0], ^(s & TAPS)};
  endfunction

  localparam logic [W-1:0] SRC_START = ONES;
  localparam bit           PKT_RESET = 1'b0;
`else
  localparam logic [W-1:0] SRC_START = '0;
  localparam bit           PKT_RESET = 1'b1;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] pkts_q, pkts_d, payload_q, payload_d, gap_q, gap_d;
  logic [CW-1:0] pkt_cnt_q, pkt_cnt_d, flit_cnt_q, flit_cnt_d, gap_cnt_q, gap_cnt_d;
  logic [W-1:0]  pattern_q, pattern_d;
  logic [N-1:0]  op_a_q, op_a_d, op_b_q, op_b_d, sig_q, sig_d;
  logic          op_valid_q, op_valid_d, busy_q, busy_d, done_q, done_d;

  logic [W-1:0]  flit, src_adv;
  logic          last_pkt;

  // Flit to drive this SEND cycle and the source value to keep afterwards
  always_comb begin
`ifdef ADDER_SCHED_LFSR_EN
    flit    = pattern_q;
    src_adv = lfsr_next(pattern_q);
`else
    flit    = therm_next(pattern_q);
    src_adv = flit;
`endif
  end

  // Next-state, counters, registered outputs and signature
  always_comb begin
    state_d    = state_q;
    pkts_d     = pkts_q;
    payload_d  = payload_q;
    gap_d      = gap_q;
    pkt_cnt_d  = pkt_cnt_q;
    flit_cnt_d = flit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    pattern_d  = pattern_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_valid_d = 1'b0;
    busy_d     = (state_q != IDLE);
    done_d     = 1'b0;
    sig_d      = sig_q;
    last_pkt   = (pkt_cnt_q == pkts_q - CW'(1));

    // sum_in reflects the flit currently on op_a/op_b
    if (op_valid_q) sig_d = {sig_q[N-2:0], sig_q[N-1]} ^ sum_in;

    case (state_q)
      IDLE: begin
        if (start) begin
          pkts_d     = cfg_pkts;
          payload_d  = cfg_payload;
          gap_d      = cfg_gap;
          pkt_cnt_d  = '0;
          flit_cnt_d = '0;
          gap_cnt_d  = '0;
          pattern_d  = SRC_START;
          sig_d      = '0;
          state_d    = (cfg_pkts == '0 || cfg_payload == '0) ? DONE : SEND;
        end
      end
      SEND: begin
        op_valid_d = 1'b1;
        op_a_d     = flit[N-1:0];
        op_b_d     = flit[W-1:N];
        pattern_d  = src_adv;
        if (flit_cnt_q == payload_q - CW'(1)) begin
          flit_cnt_d = '0;
          if (gap_q != '0) begin
            state_d   = GAP;
            gap_cnt_d = '0;
          end else if (last_pkt) begin
            state_d = DONE;
          end else begin
            pkt_cnt_d = pkt_cnt_q + CW'(1);
            if (PKT_RESET) pattern_d = '0;
          end
        end else begin
          flit_cnt_d = flit_cnt_q + CW'(1);
        end
      end
      GAP: begin
        // op_a/op_b hold their last flit so the gap adds no toggle activity
        if (gap_cnt_q == gap_q - CW'(1)) begin
          gap_cnt_d = '0;
          if (last_pkt) begin
            state_d = DONE;
          end else begin
            state_d   = SEND;
            pkt_cnt_d = pkt_cnt_q + CW'(1);
            if (PKT_RESET) pattern_d = '0;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + CW'(1);
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over everything, including start; the signature is frozen
    if (abort) begin
      state_d    = IDLE;
      op_valid_d = 1'b0;
      op_a_d     = '0;
      op_b_d     = '0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      sig_d      = sig_q;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pkts_q     <= '0;
      payload_q  <= '0;
      gap_q      <= '0;
      pkt_cnt_q  <= '0;
      flit_cnt_q <= '0;
      gap_cnt_q  <= '0;
      pattern_q  <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sig_q      <= '0;
    end else begin
      state_q    <= state_d;
      pkts_q     <= pkts_d;
      payload_q  <= payload_d;
      gap_q      <= gap_d;
      pkt_cnt_q  <= pkt_cnt_d;
      flit_cnt_q <= flit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      pattern_q  <= pattern_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_valid_q <= op_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sig_q      <= sig_d;
    end
  end

  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign op_valid = op_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sig      = sig_q;

endmodule

// File: tb/tb_adder_traffic_sched.sv
// tb_adder_traffic_sched: randomized runs of the traffic scheduler checked
// cycle by cycle against a packet/flit-level reference model.
module tb_adder_traffic_sched;
  localparam int N   = 15;
  localparam int SEG = 4;
  localparam int CW  = 16;
  localparam int W   = 2 * N;
  localparam int NF  = (W - 1) / SEG;   // fill steps (= drain steps)
  localparam int PER = 2 * NF + 1;      // pattern period incl. the all-zero step

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [CW-1:0] cfg_pkts = '0, cfg_payload = '0, cfg_gap = '0;
  logic [N-1:0]  sum_in, op_a, op_b, sig;
  logic          op_valid, busy, done;

  adder_traffic_sched #(.N(N), .SEG(SEG), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_pkts(cfg_pkts), .cfg_payload(cfg_payload), .cfg_gap(cfg_gap),
    .sum_in(sum_in), .op_a(op_a), .op_b(op_b), .op_valid(op_valid),
    .busy(busy), .done(done), .sig(sig)
  );

  // the shared adder
  assign sum_in = op_a + op_b;

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // observed per-cycle trace, cycle k after the start edge at index k-1
  logic         q_v[$], q_done[$], q_busy[$];
  logic [N-1:0] q_a[$], q_b[$], q_sig[$];

  // expected trace up to and including the done cycle
  logic         e_v[$];
  logic [N-1:0] e_a[$], e_b[$];
  logic [N-1:0] e_sig;
  logic [N-1:0] last_a = '0, last_b = '0;   // operand values the DUT should be holding

  // Flit f of a packet: f mod PER picks fill k=SEG*(i+1), drain k=SEG*(2NF-i), or zero
  function automatic logic [W-1:0] therm(input int idx);
    logic [W-1:0] p;
    int i;
    p = '0;
    i = idx % PER;
    if (i < NF)          for (int b = 0; b < SEG * (i + 1); b++) p[W-1-b] = 1'b1;
    else if (i < 2 * NF) for (int b = 0; b < SEG * (2 * NF - i); b++) p[b] = 1'b1;
    return p;
  endfunction

  task automatic build_model(input int pkts, input int payload, input int gap);
    logic [W-1:0] p;
    e_v.delete(); e_a.delete(); e_b.delete();
    e_sig = '0;
    if (pkts != 0 && payload != 0) begin
      for (int k = 0; k < pkts; k++) begin
        for (int f = 0; f < payload; f++) begin
          p = therm(f);
          last_a = p[N-1:0];
          last_b = p[W-1:N];
          e_v.push_back(1'b1); e_a.push_back(last_a); e_b.push_back(last_b);
          e_sig = {e_sig[N-2:0], e_sig[N-1]} ^ N'(last_a + last_b);
        end
        for (int g = 0; g < gap; g++) begin
          e_v.push_back(1'b0); e_a.push_back(last_a); e_b.push_back(last_b);
        end
      end
    end
    // done cycle
    e_v.push_back(1'b0); e_a.push_back(last_a); e_b.push_back(last_b);
  endtask

  // Start a run and record outputs each cycle; cfg_* and start are scrambled
  // while the run is in progress, which must have no effect.
  task automatic capture(input int pkts, input int payload, input int gap, input int abort_at);
    int nval, post;
    bit fin;
    nval = 0; post = -1; fin = 1'b0;
    q_v.delete(); q_done.delete(); q_busy.delete(); q_a.delete(); q_b.delete(); q_sig.delete();
    @(negedge clk);
    cfg_pkts = CW'(pkts); cfg_payload = CW'(payload); cfg_gap = CW'(gap);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cfg_pkts = CW'($urandom); cfg_payload = CW'($urandom); cfg_gap = CW'($urandom);
    for (int k = 1; k <= 3000 && !fin; k++) begin
      @(negedge clk);
      q_v.push_back(op_valid); q_done.push_back(done); q_busy.push_back(busy);
      q_a.push_back(op_a); q_b.push_back(op_b); q_sig.push_back(sig);
      if (op_valid) nval++;
      abort = 1'b0;
      if (post >= 0) begin
        post--;
        if (post == 0) fin = 1'b1;
      end else if (done) begin
        post = 1;
      end else if (abort_at >= 0 && nval == abort_at + 1) begin
        abort = 1'b1;
        post = 4;
      end
      start = (post < 0 && !done) ? ($urandom_range(0, 3) == 0) : 1'b0;
      cfg_pkts = CW'($urandom); cfg_payload = CW'($urandom); cfg_gap = CW'($urandom);
    end
    start = 1'b0; abort = 1'b0;
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL capture_timeout: run %0d/%0d/%0d did not finish, got %0d cycles", pkts, payload, gap, q_v.size());
    end
  endtask

  task automatic test_run_cfg(input int pkts, input int payload, input int gap, input string nm);
    int L;
    build_model(pkts, payload, gap);
    capture(pkts, payload, gap, -1);
    L = e_v.size();
    checks++;
    if (q_v.size() !== L + 1) begin
      errors++;
      $display("FAIL %s length: got %0d cycles, want %0d", nm, q_v.size(), L + 1);
    end
    for (int i = 0; i < L && i < q_v.size(); i++) begin
      checks++;
      if ({q_v[i], q_a[i], q_b[i], q_done[i], q_busy[i]} !==
          {e_v[i], e_a[i], e_b[i], (i == L - 1), 1'b1}) begin
        errors++;
        $display("FAIL %s cycle%0d: got v=%0b a=%h b=%h done=%0b busy=%0b, want v=%0b a=%h b=%h done=%0b busy=1",
                 nm, i + 1, q_v[i], q_a[i], q_b[i], q_done[i], q_busy[i],
                 e_v[i], e_a[i], e_b[i], (i == L - 1));
      end
    end
    if (q_v.size() > L) begin
      checks++;
      if ({q_v[L], q_done[L], q_busy[L]} !== 3'b000) begin
        errors++;
        $display("FAIL %s after_done: got v/done/busy=%b, want 000", nm, {q_v[L], q_done[L], q_busy[L]});
      end
      checks++;
      if (q_sig[L-1] !== e_sig) begin
        errors++;
        $display("FAIL %s sig: got %h, want %h", nm, q_sig[L-1], e_sig);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({op_a, op_b, op_valid, busy, done, sig} !== '0) begin
      errors++;
      $display("FAIL reset: got a=%h b=%h v=%0b busy=%0b done=%0b sig=%h, want all 0", op_a, op_b, op_valid, busy, done, sig);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({op_a, op_b, op_valid, busy, done, sig} !== '0) begin
      errors++;
      $display("FAIL idle: got a=%h b=%h v=%0b busy=%0b done=%0b sig=%h, want all 0", op_a, op_b, op_valid, busy, done, sig);
    end
  endtask

  task automatic test_single;
    test_run_cfg(1, 1, 0, "single");
    checks++;
    if (q_v.size() < 2 || {q_v[0], q_b[0], q_a[0], q_done[1], q_sig[1]} !== {1'b1, 15'h7800, 15'h0000, 1'b1, 15'h7800}) begin
      errors++;
      $display("FAIL single_const: got v=%0b b=%h a=%h done@2=%0b sig=%h, want 1 7800 0000 1 7800",
               q_v[0], q_b[0], q_a[0], q_done[1], q_sig[1]);
    end
  endtask

  task automatic test_wrap;
    logic [N-1:0] wb[5], wa[5];
    int idx[5];
    idx = '{0, 6, 7, 14, 15};
    wb  = '{15'h7800, 15'h7FFF, 15'h1FFF, 15'h0000, 15'h7800};
    wa  = '{15'h0000, 15'h7FFC, 15'h7FFF, 15'h0000, 15'h0000};
    test_run_cfg(1, 16, 0, "wrap");
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (q_v.size() <= idx[j] || {q_b[idx[j]], q_a[idx[j]]} !== {wb[j], wa[j]}) begin
        errors++;
        $display("FAIL wrap_flit%0d: got b=%h a=%h, want b=%h a=%h", idx[j], q_b[idx[j]], q_a[idx[j]], wb[j], wa[j]);
      end
    end
  endtask

  task automatic test_traffic;
    int nv, dc;
    test_run_cfg(10, 20, 7, "traffic");
    nv = 0; dc = 0;
    for (int i = 0; i < q_v.size(); i++) begin
      if (q_v[i]) nv++;
      if (q_done[i] && dc == 0) dc = i + 1;
    end
    checks++;
    if (nv !== 200) begin
      errors++;
      $display("FAIL traffic_valid_count: got %0d, want 200", nv);
    end
    checks++;
    if (dc !== 271) begin
      errors++;
      $display("FAIL traffic_done_cycle: got T+%0d, want T+271", dc);
    end
  endtask

  task automatic test_zero;
    test_run_cfg(0, 5, 3, "zero_pkts");
    test_run_cfg(3, 0, 2, "zero_payload");
    checks++;
    if (q_v.size() < 2 || {q_done[0], q_v[0], q_busy[1], q_done[1]} !== 4'b1000) begin
      errors++;
      $display("FAIL zero_timing: got done@1=%0b v@1=%0b busy@2=%0b done@2=%0b, want 1 0 0 0",
               q_done[0], q_v[0], q_busy[1], q_done[1]);
    end
  endtask

  task automatic test_abort;
    logic [W-1:0] p;
    logic [N-1:0] es;
    es = '0;
    for (int f = 0; f < 2; f++) begin
      p = therm(f);
      es = {es[N-2:0], es[N-1]} ^ N'(p[N-1:0] + p[W-1:N]);
    end
    capture(2, 10, 3, 2);
    checks++;
    if (q_v.size() < 7 || {q_v[3], q_a[3], q_b[3], q_busy[3], q_done[3]} !== '0) begin
      errors++;
      $display("FAIL abort_next: got v=%0b a=%h b=%h busy=%0b done=%0b, want all 0", q_v[3], q_a[3], q_b[3], q_busy[3], q_done[3]);
    end
    for (int i = 4; i < q_v.size(); i++) begin
      checks++;
      if ({q_v[i], q_done[i], q_busy[i]} !== 3'b000) begin
        errors++;
        $display("FAIL abort_idle cycle%0d: got v/done/busy=%b, want 000", i + 1, {q_v[i], q_done[i], q_busy[i]});
      end
    end
    checks++;
    if (q_sig[q_sig.size()-1] !== es) begin
      errors++;
      $display("FAIL abort_sig_hold: got %h, want %h", q_sig[q_sig.size()-1], es);
    end
    last_a = '0; last_b = '0;
    test_run_cfg(1, 3, 0, "restart");
    checks++;
    if (q_b[0] !== 15'h7800) begin
      errors++;
      $display("FAIL restart_flit0: got b=%h, want 7800", q_b[0]);
    end
  endtask

  task automatic test_random;
    for (int r = 0; r < 8; r++)
      test_run_cfg($urandom_range(1, 4), $urandom_range(1, 20), $urandom_range(0, 5), "random");
  endtask

  initial begin
    test_reset;
    test_single;
    test_wrap;
    test_traffic;
    test_zero;
    test_abort;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
